// File: rtl/sm3_pkg.sv
// Shared constants and FSM encoding for the SM3 message unpadding slice.
// Block geometry, length field width and the unpadder state type.
package sm3_pkg;

  localparam int BLOCK_W      = 512;
  localparam int WORD_W       = 32;
  localparam int LEN_W        = 64;
  localparam int MAX_MSG_BITS = 447;
  localparam int MLEN_W       = 9;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_STREAM = 2'd2,
    S_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/message_unpadding_if.sv
// Word stream handshake between the unpadder and its consumer.
// A word moves when m_valid and m_ready are both high.
interface message_unpadding_if;
  import sm3_pkg::*;

  logic              m_valid;
  logic [WORD_W-1:0] m_word;
  logic              m_last;
  logic              m_ready;

  modport master (
    output m_valid,
    output m_word,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_word,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/sm3_pad_check.sv
// Combinational validation of a padded block: length range and, with
// MESSAGE_UNPADDING_CHECK_EN, the marker bit and the zero run as well.
module sm3_pad_check
  import sm3_pkg::*;
(
  input  logic [BLOCK_W-1:0] blk,
  output logic               ok,
  output logic [MLEN_W-1:0]  len
);

`ifdef MESSAGE_UNPADDING_CHECK_EN
  localparam bit SHAPE_EN = 1'b1;
`else
  localparam bit SHAPE_EN = 1'b0;
`endif

  logic [LEN_W-1:0] l;
  logic             range_ok;
  logic             shape_ok;

  assign l        = blk[LEN_W-1:0];
  assign range_ok = (l <= LEN_W'(MAX_MSG_BITS));
  assign len      = l[MLEN_W-1:0];

  // marker must sit right after the message, zeros down to the length field
  always_comb begin
    shape_ok = 1'b1;
    for (int i = LEN_W; i < BLOCK_W; i++) begin
      if (i == BLOCK_W - 1 - int'(len)) begin
        shape_ok = shape_ok & blk[i];
      end else if (i < BLOCK_W - 1 - int'(len)) begin
        shape_ok = shape_ok & ~blk[i];
      end
    end
  end

  assign ok = range_ok && (shape_ok || !SHAPE_EN);

endmodule

// File: rtl/message_unpadding.sv
// Recovers message words from a padded block and streams them out.
// Optional strict padding check: define MESSAGE_UNPADDING_CHECK_EN.
module message_unpadding #(
  parameter int BLOCK_W = sm3_pkg::BLOCK_W,
  parameter int WORD_W  = sm3_pkg::WORD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BLOCK_W-1:0]  padded_in,
  message_unpadding_if.master m,
  output logic [8:0]          m_len,
  output logic                busy,
  output logic                done,
  output logic                err
);
  import sm3_pkg::*;

  state_t             state_q;
  state_t             state_d;
  logic [BLOCK_W-1:0] blk_q;
  logic [8:0]         len_q;
  logic               bad_q;
  logic [3:0]         cnt_q;
  logic [3:0]         lastidx_q;

  logic               ok;
  logic [8:0]         len;
  logic [3:0]         lastidx_d;
  logic               stream;
  logic               is_last;
  logic               xfer;
  logic [8:0]         base;
  logic [8:0]         rem;
  logic [WORD_W-1:0]  raw;
  logic [WORD_W-1:0]  mask;

  sm3_pad_check u_chk (
    .blk (blk_q),
    .ok  (ok),
    .len (len)
  );

  assign lastidx_d = 4'((len - 9'd1) >> 5);
  assign stream    = (state_q == S_STREAM);
  assign is_last   = (cnt_q == lastidx_q);
  assign xfer      = stream && m.m_ready;

  assign base = 9'(BLOCK_W - 1) - {cnt_q, 5'b0};
  assign rem  = len_q - {cnt_q, 5'b0};
  assign raw  = blk_q[base -: WORD_W];
  assign mask = (rem >= 9'd32) ? '1 : ~({WORD_W{1'b1}} >> rem);

  assign m.m_valid = stream;
  assign m.m_word  = stream ? (raw & mask) : '0;
  assign m.m_last  = stream && is_last;
  assign m_len     = len_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);
  assign err       = done && bad_q;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: one CHECK cycle, stream until the last word moves
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_CHECK;
      S_CHECK:  state_d = (ok && len != 9'd0) ? S_STREAM : S_FINISH;
      S_STREAM: if (xfer && is_last) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // block capture, length/verdict latch and word counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_q     <= '0;
      len_q     <= '0;
      bad_q     <= 1'b0;
      cnt_q     <= '0;
      lastidx_q <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        blk_q <= padded_in;
      end
      if (state_q == S_CHECK) begin
        len_q     <= ok ? len : '0;
        bad_q     <= !ok;
        cnt_q     <= '0;
        lastidx_q <= lastidx_d;
      end
      if (xfer && !is_last) begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

endmodule
